// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative radix-2 multiply/divide unit for the EX stage.
//   Implements MULT, MULTU, DIV and DIVU. It also holds the architectural
//   HI/LO registers and accepts MTHI/MTLO writes.
//   Latency is fixed: Start accepted at edge E0, result written at E33.
//
// Ports
//   CLK          clock; all state updates on the rising edge
//   RST_RegFile  asynchronous active-low reset
//   Start        one-cycle request, sampled only while idle
//   Op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcA, SrcB   rs / rt operands (RD1 / RD2)
//   WE_Hi, WE_Lo MTHI / MTLO write enables
//   WD           MTHI / MTLO write data
//   Hi, Lo       HI / LO registers
//   Busy         operation in flight
//   Done         one-cycle pulse after HI/LO update
//   DivZero      pulses with Done when a divide had SrcB = 0
//
// Configuration
//   MULDIV_DIV_EN  defined: divide datapath present.
//                  undefined: DIV/DIVU complete in one cycle with
//                  Done only; HI/LO are not touched.

module mul_div_unit (
  input  logic        CLK,
  input  logic        RST_RegFile,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        WE_Hi,
  input  logic        WE_Lo,
  input  logic [31:0] WD,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  count_q;
  logic [31:0] acc_hi_q;
  logic [31:0] acc_lo_q;
  logic [31:0] opb_q;
  logic        sign_q;
`ifdef MULDIV_DIV_EN
  logic        is_div_q;
  logic        rem_sign_q;
  logic [32:0] div_shift;
  logic [31:0] div_trial;
  logic        div_ge;
  logic        div_zero;
  logic [31:0] quot_fixed;
  logic [31:0] rem_fixed;
`endif

  logic        start_op;
  logic        finish;
  logic        quick_done;
  logic        is_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic [63:0] prod_mag;
  logic [63:0] prod_fixed;
  logic        mt_write;

  // Signed ops work on magnitudes; 0x80000000 negates to itself, which
  // is exactly its unsigned magnitude.
  assign is_signed = ~Op[0];
  assign mag_a     = (is_signed && SrcA[31]) ? (~SrcA + 32'd1) : SrcA;
  assign mag_b     = (is_signed && SrcB[31]) ? (~SrcB + 32'd1) : SrcB;

  // MTHI/MTLO only land when idle and not colliding with a new request.
  assign mt_write  = (state_q == IDLE) && !Start;

  always_ff @(posedge CLK or negedge RST_RegFile) begin
    if (!RST_RegFile) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_op   = 1'b0;
    finish     = 1'b0;
    quick_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
`ifdef MULDIV_DIV_EN
          start_op = 1'b1;
          state_d  = CALC;
`else
          // Without a divider, divides just acknowledge with Done.
          if (Op[1]) begin
            quick_done = 1'b1;
          end else begin
            start_op = 1'b1;
            state_d  = CALC;
          end
`endif
        end
      end
      CALC: begin
        if (count_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One iteration of the datapath. For multiply, {acc_hi,acc_lo} is the
  // product accumulator with the multiplier shifting out of acc_lo. For
  // divide, acc_hi is the partial remainder and acc_lo shifts the
  // dividend out while quotient bits shift in.
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
    step_hi = mul_sum[32:1];
    step_lo = {mul_sum[0], acc_lo_q[31:1]};
`ifdef MULDIV_DIV_EN
    // The 33-bit shifted remainder is compared in full. When it is at
    // least the divisor, the true difference fits in 32 bits, so a 32-bit
    // subtract is enough.
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_trial = div_shift[31:0] - opb_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_trial : div_shift[31:0];
      step_lo = {acc_lo_q[30:0], div_ge};
    end
`endif
  end

  assign prod_mag   = {acc_hi_q, acc_lo_q};
  assign prod_fixed = sign_q ? (~prod_mag + 64'd1) : prod_mag;
`ifdef MULDIV_DIV_EN
  assign quot_fixed = sign_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
  assign rem_fixed  = rem_sign_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
  assign div_zero   = is_div_q && (opb_q == 32'd0);
`endif

  always_ff @(posedge CLK or negedge RST_RegFile) begin
    if (!RST_RegFile) begin
      count_q    <= 5'd0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= 32'd0;
      opb_q      <= 32'd0;
      sign_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q   <= 1'b0;
      rem_sign_q <= 1'b0;
`endif
    end else if (start_op) begin
      count_q    <= 5'd0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= mag_a;
      opb_q      <= mag_b;
      sign_q     <= is_signed & (SrcA[31] ^ SrcB[31]);
`ifdef MULDIV_DIV_EN
      is_div_q   <= Op[1];
      rem_sign_q <= is_signed & SrcA[31];
`endif
    end else if (state_q == CALC) begin
      // The counter wraps from 31 to 0 on the last iteration.
      count_q  <= count_q + 5'd1;
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
    end
  end

  always_ff @(posedge CLK or negedge RST_RegFile) begin
    if (!RST_RegFile) begin
      Hi <= 32'd0;
      Lo <= 32'd0;
    end else if (finish) begin
`ifdef MULDIV_DIV_EN
      if (is_div_q) begin
        // A divide by zero leaves HI/LO untouched.
        if (!div_zero) begin
          Hi <= rem_fixed;
          Lo <= quot_fixed;
        end
      end else begin
        {Hi, Lo} <= prod_fixed;
      end
`else
      {Hi, Lo} <= prod_fixed;
`endif
    end else if (mt_write) begin
      if (WE_Hi) begin
        Hi <= WD;
      end
      if (WE_Lo) begin
        Lo <= WD;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_RegFile) begin
    if (!RST_RegFile) begin
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Busy    <= (state_d != IDLE);
      Done    <= finish | quick_done;
`ifdef MULDIV_DIV_EN
      DivZero <= finish & div_zero;
`else
      DivZero <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Bench for mul_div_unit. A transaction-level reference model computes
//   HI/LO with plain 64-bit arithmetic and counts down the fixed latency.
//   A compare process checks every DUT output against the model on each
//   falling edge. Directed cases pin known results. A long randomized
//   phase then mixes operations, MTHI/MTLO writes and stray Starts.

module tb_mul_div_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        CLK;
  logic        RST_RegFile;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        WE_Hi;
  logic        WE_Lo;
  logic [31:0] WD;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  int checks   = 0;
  int failures = 0;

  mul_div_unit dut (
    .CLK         (CLK),
    .RST_RegFile (RST_RegFile),
    .Start       (Start),
    .Op          (Op),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .WE_Hi       (WE_Hi),
    .WE_Lo       (WE_Lo),
    .WD          (WD),
    .Hi          (Hi),
    .Lo          (Lo),
    .Busy        (Busy),
    .Done        (Done),
    .DivZero     (DivZero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Architectural result {HI, LO} of one operation.
  function automatic logic [63:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 64'd0;
    case (op)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b != 32'd0) begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b != 32'd0) begin
          res = {a % b, a / b};
        end
      end
    endcase
    return res;
  endfunction

  // Reference model state
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_busy;
  logic        m_done;
  logic        m_dz;
  int          m_left;
  logic [63:0] m_res;
  logic        m_res_dz;

  always @(posedge CLK or negedge RST_RegFile) begin
    if (!RST_RegFile) begin
      m_hi     <= 32'd0;
      m_lo     <= 32'd0;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_dz     <= 1'b0;
      m_left   <= 0;
      m_res    <= 64'd0;
      m_res_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_dz   <= m_res_dz;
          if (!m_res_dz) begin
            m_hi <= m_res[63:32];
            m_lo <= m_res[31:0];
          end
        end else begin
          m_left <= m_left - 1;
        end
      end else if (Start) begin
        if (Op[1] && !DIV_EN) begin
          m_done <= 1'b1;
        end else begin
          m_res    <= ref_result(Op, SrcA, SrcB);
          m_res_dz <= Op[1] && (SrcB == 32'd0);
          m_busy   <= 1'b1;
          m_left   <= 33;
        end
      end else begin
        if (WE_Hi) m_hi <= WD;
        if (WE_Lo) m_lo <= WD;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual,
               expected, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_RegFile) begin
      checkOutput("cyc_hi", 64'(Hi), 64'(m_hi));
      checkOutput("cyc_lo", 64'(Lo), 64'(m_lo));
      checkOutput("cyc_busy", 64'(Busy), 64'(m_busy));
      checkOutput("cyc_done", 64'(Done), 64'(m_done));
      checkOutput("cyc_divzero", 64'(DivZero), 64'(m_dz));
    end
  end

  // Drives one cycle of inputs. Pulse inputs are cleared just after the
  // sampling edge.
  task automatic applyStimulus(input bit start, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input bit we_hi, input bit we_lo,
                               input logic [31:0] wd);
    Start = start;
    Op    = op;
    SrcA  = a;
    SrcB  = b;
    WE_Hi = we_hi;
    WE_Lo = we_lo;
    WD    = wd;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    WE_Hi = 1'b0;
    WE_Lo = 1'b0;
  endtask

  task automatic waitDone(output int cycles, output int busy_cycles,
                          output bit found);
    cycles      = 0;
    busy_cycles = 0;
    found       = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      cycles++;
      if (Busy) busy_cycles++;
      if (Done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic runOp(input string name, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input int exp_cycles, input int exp_busy,
                       input bit exp_dz);
    int  cyc;
    int  bcyc;
    bit  found;
    applyStimulus(1'b1, op, a, b, 1'b0, 1'b0, 32'd0);
    waitDone(cyc, bcyc, found);
    $display("[TB] %s done after %0d cycles", name, cyc);
    checkOutput({name, "_latency"}, 64'(cyc), 64'(exp_cycles));
    checkOutput({name, "_busy_cycles"}, 64'(bcyc), 64'(exp_busy));
    checkOutput({name, "_hi"}, 64'(Hi), 64'(exp_hi));
    checkOutput({name, "_lo"}, 64'(Lo), 64'(exp_lo));
    checkOutput({name, "_divzero"}, 64'(DivZero), 64'(exp_dz));
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  seen;
    int  cyc;
    int  bcyc;
    bit  found;
    RST_RegFile = 1'b0;
    Start = 1'b0;
    Op    = 2'b00;
    SrcA  = 32'd0;
    SrcB  = 32'd0;
    WE_Hi = 1'b0;
    WE_Lo = 1'b0;
    WD    = 32'd0;

    repeat (2) @(negedge CLK);
    checkOutput("reset_hi", 64'(Hi), 64'd0);
    checkOutput("reset_lo", 64'(Lo), 64'd0);
    checkOutput("reset_busy", 64'(Busy), 64'd0);
    checkOutput("reset_done", 64'(Done), 64'd0);
    checkOutput("reset_divzero", 64'(DivZero), 64'd0);
    #2 RST_RegFile = 1'b1;

    checkOutput("model_mult", ref_result(2'b00, 32'hFFFF_FFFD, 32'd7),
                64'hFFFF_FFFF_FFFF_FFEB);
    checkOutput("model_multu", ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
                64'hFFFF_FFFE_0000_0001);
    checkOutput("model_div", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2),
                64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("model_divmin", ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF),
                64'h0000_0000_8000_0000);

    // Reset in the middle of a MULTU aborts it with HI/LO cleared.
    @(negedge CLK);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'h5555_AAAA);
    applyStimulus(1'b1, 2'b01, 32'h0001_2345, 32'h0006_789A, 1'b0, 1'b0, 32'd0);
    repeat (10) @(negedge CLK);
    #2 RST_RegFile = 1'b0;
    #1;
    checkOutput("midreset_hi", 64'(Hi), 64'd0);
    checkOutput("midreset_lo", 64'(Lo), 64'd0);
    checkOutput("midreset_busy", 64'(Busy), 64'd0);
    @(negedge CLK);
    #2 RST_RegFile = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Done) seen++;
    end
    checkOutput("midreset_no_done", 64'(seen), 64'd0);

    // Back-to-back: each runOp issues Start during the previous Done cycle.
    runOp("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7,
          32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 33, 1'b0);
    runOp("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001, 34, 33, 1'b0);
`ifdef MULDIV_DIV_EN
    runOp("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33, 1'b0);
    runOp("div_mostneg", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0000_0000, 32'h8000_0000, 34, 33, 1'b0);
`else
    runOp("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFE, 32'h0000_0001, 1, 0, 1'b0);
    runOp("div_mostneg", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001, 1, 0, 1'b0);
`endif

    // Divide by zero keeps the MTHI/MTLO preload.
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0000_0011);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_0022);
`ifdef MULDIV_DIV_EN
    runOp("divu_by0", 2'b11, 32'd5, 32'd0, 32'h11, 32'h22, 34, 33, 1'b1);
`else
    runOp("divu_by0", 2'b11, 32'd5, 32'd0, 32'h11, 32'h22, 1, 0, 1'b0);
`endif

    // An MTLO write and a second Start during Busy are both dropped.
    @(negedge CLK);
    applyStimulus(1'b1, 2'b01, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0);
    repeat (4) @(negedge CLK);
    applyStimulus(1'b1, 2'b00, 32'd9, 32'd9, 1'b0, 1'b1, 32'h0000_AAAA);
    waitDone(cyc, bcyc, found);
    checkOutput("dropped_lo", 64'(Lo), 64'd42);
    checkOutput("dropped_hi", 64'(Hi), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Done) seen++;
    end
    checkOutput("dropped_single_done", 64'(seen), 64'd0);

    // Randomized mix checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)),
                    pickOperand(), pickOperand(),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom);
    end
    repeat (40) applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit for the EX stage of the pipelined MIPS core, implementing MULT, MULTU, DIV and DIVU.

- Consumes the two source operands read from the register file (rs on RD1, rt on RD2).
- Holds the architectural HI and LO registers and supports MTHI/MTLO writes.
- Reports Busy so the hazard unit stalls the front end while an operation is in flight.
- Is sequential (radix-2, one bit per cycle) with a fixed, deterministic latency.

## Interface

Parameters: none; width is fixed at 32 bits.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST_RegFile  in  1  reset, asynchronous, active-low
- Start  in  1  one-cycle request; sampled only in IDLE
- Op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- SrcA  in  32  rs operand (from RD1)
- SrcB  in  32  rt operand (from RD2)
- WE_Hi  in  1  MTHI write enable
- WE_Lo  in  1  MTLO write enable
- WD  in  32  MTHI/MTLO write data
- Hi  out  32  HI register
- Lo  out  32  LO register
- Busy  out  1  operation in flight; front end must stall on it
- Done  out  1  one-cycle pulse: HI/LO updated on this cycle's preceding edge
- DivZero  out  1  pulses together with Done when a DIV/DIVU had SrcB = 0

## Operation

States: IDLE, CALC, FIX.

- **IDLE**
  - On Start=1, the unit latches Op and the operand magnitudes.
    - Signed ops (MULT/DIV): magnitude = two's-complement absolute value; 0x80000000 maps to 0x80000000 unsigned.
    - Unsigned ops (MULTU/DIVU): operands taken as-is.
  - It records sign flags: product/quotient sign = SrcA[31]^SrcB[31]; remainder sign = SrcA[31]. Both are forced to 0 for unsigned ops.
  - It clears the 5-bit iteration counter and goes to CALC.
- **CALC**: one iteration per cycle, 32 iterations; the counter wraps from 31 to 0 on entry to FIX.
  - Multiply: shift-add on a 64-bit accumulator with a 33-bit partial sum to hold the carry.
  - Divide: restoring division; 33-bit trial subtract of the divisor from the partial remainder, quotient bit shifted in.
- **FIX**: applies the sign correction, then writes the result and returns to IDLE.
  - Multiply: {Hi,Lo} = 64-bit product, negated if the sign flag is set.
  - Divide: Lo = quotient, Hi = remainder, each negated per its own sign flag.
  - Divide with SrcB = 0: Hi/Lo are left unchanged and DivZero pulses; latency is unchanged.
  - Most-negative case: DIV 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0.
- **MTHI/MTLO**
  - WE_Hi/WE_Lo write WD into Hi/Lo only in IDLE, and only when Start=0.
  - Writes are dropped while Busy, and dropped when they coincide with Start.
  - WE_Hi and WE_Lo may be asserted together; both registers take WD.
- **Start outside IDLE**: ignored; no queuing.

## Timing

- **Reset** (asynchronous, takes effect immediately at any time): Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, state IDLE, counter 0. Reset mid-operation aborts the operation with no HI/LO update.
- **Start accepted at edge E0**:
  - Busy=1 from E0 through E33; it falls at E33.
  - Edges E1–E32 are the CALC iterations; the state is FIX after E32.
  - At E33: Hi/Lo written, Done=1 and DivZero (if applicable) for one cycle, Busy=0.
- **Back-to-back**: a new Start is accepted earliest at E34.
  - Start=1 held during the Done cycle (the cycle after E33) is sampled at E34 and starts the next operation.
  - Hi/Lo read during the Done cycle show the new result.
- **Outputs**: Hi, Lo, Busy, Done and DivZero are registered; none depends combinationally on inputs.
- **Clock phase**: the register file writes on the falling edge, so operands presented on SrcA/SrcB before E0 already include a same-cycle writeback.

## Configuration

- **MULDIV_DIV_EN defined**: full behaviour as above.
- **MULDIV_DIV_EN undefined**: divide datapath removed.
  - Start with Op[1]=1 is accepted at E0, but Busy stays 0.
  - Done pulses for the single cycle after E0.
  - Hi/Lo are unchanged and DivZero stays 0.
  - MULT/MULTU are unaffected.

## Test plan

- **Reset**: assert RST_RegFile mid-CALC of a MULTU -> Hi=Lo=0, Busy=0 immediately; no Done follows.
- **MULT signed**: SrcA=0xFFFFFFFD (-3), SrcB=7 -> Done 34 cycles after the Start cycle; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high for exactly 33 cycles.
- **MULTU**: 0xFFFFFFFF × 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- **DIV signed**:
  - -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- **Divide by zero**: DIVU 5 / 0 with Hi/Lo preloaded via MTHI=0x11, MTLO=0x22 -> Done and DivZero pulse at E33; Hi=0x11, Lo=0x22.
- **Dropped requests**: WE_Lo with WD=0xAAAA during Busy, and a second Start during Busy -> both ignored; Lo holds the operation result; only one Done.
